// File: rtl/rv_pkg.sv
// Shared core constants and register-address type used by the integer register file.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wsel.sv
// NWR-way priority write matcher: for one address, reports whether any enabled
// write port targets it and the data of the highest-index such port.
module regfile_wsel #(
    parameter int XLEN = 64,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]       addr_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic                hit_o,
    output logic [XLEN-1:0]     data_o
);

    // Ascending scan so the last (highest-index) matching port wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass and a per-register busy
// scoreboard used by ID to stall on RAW/WAW hazards.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NREG = rv_pkg::NREG,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic                iss_ready_o,
    input  logic                flush_i
);

    logic [XLEN-1:0] regs_w [NREG];
    logic [NREG-1:0] wr_hit_w;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            iss_fire_w;

    assign regs_w[0]   = '0;
    assign wr_hit_w[0] = 1'b0;

    // One storage word plus its write-priority matcher per architectural register.
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [XLEN-1:0] val_q;
        logic [XLEN-1:0] wdata_w;
        logic            hit_w;

        regfile_wsel #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
        ) u_wsel (
            .addr_i    (AW'(r)),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .hit_o     (hit_w),
            .data_o    (wdata_w)
        );

        always_ff @(posedge clk) begin
            if (!rst) begin
                val_q <= '0;
            end else if (hit_w) begin
                val_q <= wdata_w;
            end
        end

        assign regs_w[r]   = val_q;
        assign wr_hit_w[r] = hit_w;
    end

    // Read ports: bypass from the same-cycle writeback, else the stored value.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_w;
        logic [XLEN-1:0] byp_data_w;
        logic            byp_hit_w;

        assign addr_w = rd_addr_i[k*AW +: AW];

        regfile_wsel #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
        ) u_byp (
            .addr_i    (addr_w),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .hit_o     (byp_hit_w),
            .data_o    (byp_data_w)
        );

        always_comb begin
            rd_data_o[k*XLEN +: XLEN] = '0;
            rd_busy_o[k]              = 1'b0;
            if (rst && (addr_w != '0)) begin
                rd_data_o[k*XLEN +: XLEN] = byp_hit_w ? byp_data_w : regs_w[addr_w];
                rd_busy_o[k]              = busy_q[addr_w] && !byp_hit_w;
            end
        end
    end

    // A producer writing back this cycle frees its destination for a new issue.
    assign iss_ready_o = rst && ((iss_rd_i == '0) || !busy_q[iss_rd_i] || wr_hit_w[iss_rd_i]);
    assign iss_fire_w  = iss_valid_i && iss_ready_o && (iss_rd_i != '0);

    // Clear on writeback, then set on issue so a new producer supersedes the old one;
    // flush overrides both.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (wr_hit_w[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        if (iss_fire_w) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised bench for regfile_sb with an expected-value queue.
module tb_regfile_sb;
    import rv_pkg::*;

    localparam int W   = 64;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = $clog2(NREG);

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*W-1:0]    rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*W-1:0]    wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_pass;
    logic [W-1:0] model [NREG];

    regfile_sb #(
        .XLEN (W),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready),
        .flush_i     (flush)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [W-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*W +: W]   = d;
    endtask

    task automatic issue(input int a);
        iss_valid = 1'b1;
        iss_rd    = AW'(a);
    endtask

    // Scoreboard
    task automatic expect_v(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    function automatic logic [W-1:0] rdd(input int k);
        return rd_data[k*W +: W];
    endfunction

    initial begin
        logic [W-1:0] d0, d1;
        int a0, a1, p;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        rd_addr = '0;
        rst     = 1'b0;
        idle();

        // 1. Reset: reads and ready forced low, writes/issues discarded
        @(negedge clk);
        set_rd(0, 5); set_rd(1, 31);
        set_wr(0, 5, 64'hFFFF_0000_1111_2222);
        issue(3);
        expect_v(64'h0); expect_v(64'h0); expect_v(64'h0); expect_v(64'h0);
        #1;
        chk("rst_rd0_x5", rdd(0));
        chk("rst_rd1_x31", rdd(1));
        chk("rst_busy", W'(rd_busy));
        chk("rst_iss_ready", W'(iss_ready));
        @(negedge clk);
        idle();
        rst = 1'b1;
        issue(3);
        iss_valid = 1'b0;
        expect_v(64'h1); expect_v(64'h0); expect_v(64'h0);
        #1;
        chk("rel_iss_ready", W'(iss_ready));
        chk("rel_x5_dropped", rdd(0));
        chk("rel_busy", W'(rd_busy));

        // 2. Write/read with bypass; x0 stays zero
        @(negedge clk);
        idle();
        set_wr(0, 3, 64'hDEAD_BEEF);
        set_rd(0, 3);
        model[3] = 64'hDEAD_BEEF;
        expect_v(64'hDEAD_BEEF);
        #1 chk("x3_bypass", rdd(0));
        @(negedge clk);
        idle();
        expect_v(64'hDEAD_BEEF);
        #1 chk("x3_array", rdd(0));
        @(negedge clk);
        set_wr(0, 0, 64'h5);
        set_rd(0, 0); set_rd(1, 0);
        expect_v(64'h0); expect_v(64'h0);
        #1;
        chk("x0_bypass_rd0", rdd(0));
        chk("x0_bypass_rd1", rdd(1));
        @(negedge clk);
        idle();
        expect_v(64'h0);
        #1 chk("x0_array", rdd(1));

        // 3. Write priority: higher index port wins
        @(negedge clk);
        set_wr(0, 7, 64'h1);
        set_wr(1, 7, 64'h2);
        set_rd(0, 7);
        model[7] = 64'h2;
        expect_v(64'h2);
        #1 chk("x7_prio_bypass", rdd(0));
        @(negedge clk);
        idle();
        expect_v(64'h2);
        #1 chk("x7_prio_array", rdd(0));

        // 4. Scoreboard set, WAW stall, clear on writeback
        @(negedge clk);
        issue(9);
        expect_v(64'h1);
        #1 chk("x9_issue_ready", W'(iss_ready));
        @(negedge clk);
        issue(9);
        set_rd(1, 9);
        expect_v(64'h1); expect_v(64'h0);
        #1;
        chk("x9_busy", W'(rd_busy[1]));
        chk("x9_waw_stall", W'(iss_ready));
        @(negedge clk);
        idle();
        set_wr(1, 9, 64'h42);
        model[9] = 64'h42;
        expect_v(64'h0); expect_v(64'h1); expect_v(64'h42);
        #1;
        chk("x9_busy_bypass", W'(rd_busy[1]));
        chk("x9_ready_on_wb", W'(iss_ready));
        chk("x9_data_bypass", rdd(1));
        @(negedge clk);
        idle();
        issue(9);
        expect_v(64'h0); expect_v(64'h1);
        #1;
        chk("x9_cleared", W'(rd_busy[1]));
        chk("x9_reissue_ok", W'(iss_ready));
        @(negedge clk);
        idle();
        expect_v(64'h1);
        #1 chk("x9_busy_again", W'(rd_busy[1]));

        // 5. Same-cycle set and clear: set wins
        @(negedge clk);
        issue(4);
        @(negedge clk);
        idle();
        issue(4);
        set_wr(0, 4, 64'h1234_5678);
        model[4] = 64'h1234_5678;
        expect_v(64'h1);
        #1 chk("x4_ready_on_wb", W'(iss_ready));
        @(negedge clk);
        idle();
        set_rd(0, 4);
        expect_v(64'h1); expect_v(64'h1234_5678);
        #1;
        chk("x4_set_wins", W'(rd_busy[0]));
        chk("x4_data", rdd(0));

        // 6. Flush clears everything, overrides issue, writes still land
        @(negedge clk); issue(1);
        @(negedge clk); issue(2);
        @(negedge clk); issue(10);
        @(negedge clk);
        idle();
        set_rd(0, 1); set_rd(1, 10);
        expect_v(64'h3);
        #1 chk("pre_flush_busy", W'(rd_busy));
        flush = 1'b1;
        issue(11);
        set_wr(0, 12, 64'd77);
        model[12] = 64'd77;
        expect_v(64'h1);
        #1 chk("flush_x11_ready", W'(iss_ready));
        @(negedge clk);
        idle();
        set_rd(0, 1); set_rd(1, 2);
        expect_v(64'h0);
        #1 chk("flush_busy_x1_x2", W'(rd_busy));
        set_rd(0, 10); set_rd(1, 11);
        expect_v(64'h0);
        #1 chk("flush_busy_x10_x11", W'(rd_busy));
        set_rd(0, 4); set_rd(1, 9);
        expect_v(64'h0);
        #1 chk("flush_busy_x4_x9", W'(rd_busy));
        set_rd(0, 12);
        expect_v(64'd77);
        #1 chk("flush_write_x12", rdd(0));

        // 7. Randomised writes on both ports, read back next cycle
        for (int it = 0; it < 24; it++) begin
            @(negedge clk);
            idle();
            a0 = $urandom_range(NREG - 1, 0);
            a1 = $urandom_range(1, 0) ? a0 : $urandom_range(NREG - 1, 0);
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            p  = $urandom_range(2, 0);
            if (p != 1) set_wr(0, a0, d0);
            if (p != 0) set_wr(1, a1, d1);
            if (p != 1 && a0 != 0) model[a0] = d0;
            if (p != 0 && a1 != 0) model[a1] = d1;
            @(negedge clk);
            idle();
            set_rd(0, a0); set_rd(1, a1);
            expect_v(model[a0]); expect_v(model[a1]);
            #1;
            chk("rand_rd0", rdd(0));
            chk("rand_rd1", rdd(1));
        end

        // 8. Reset mid-operation clears array and scoreboard
        @(negedge clk);
        idle();
        issue(5);
        @(negedge clk);
        idle();
        rst = 1'b0;
        set_wr(1, 3, 64'hFFFF_FFFF);
        issue(6);
        @(negedge clk);
        idle();
        rst = 1'b1;
        set_rd(0, 3); set_rd(1, 5);
        expect_v(64'h0); expect_v(64'h0);
        #1;
        chk("rst2_x3_cleared", rdd(0));
        chk("rst2_busy_cleared", W'(rd_busy));
        set_rd(1, 6);
        expect_v(64'h0);
        #1 chk("rst2_x6_not_busy", W'(rd_busy[1]));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
